// File: rtl/inta_ack_responder.sv
// Interrupt-acknowledge responder for an 8259-style PIC (8086 two-pulse INTA).
// Optional auto-EOI clear pulse (ISR_CLR) is built when AUTO_EOI_EN is defined.
module inta_ack_responder #(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INTA_N,
    input  logic       SP_EN,
    input  logic [7:0] ICW3,
    input  logic [4:0] ICW2_T,
    input  logic       INT_REQ_VALID,
    input  logic [2:0] INT_LEVEL,
    input  logic [2:0] CAS_IN,
    output logic       INT,
    output logic [2:0] CAS_OUT,
    output logic       CAS_OE,
    output logic [7:0] DATA_OUT,
    output logic       DATA_OE,
    output logic [7:0] ISR_SET,
    output logic       SELECTED
`ifdef AUTO_EOI_EN
    ,
    output logic [7:0] ISR_CLR
`endif
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_ACK2 = 2'd3;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

    logic [SYNC_N-1:0] sync_q;
    logic              prev_q;
    logic              fall_s, rise_s;
    logic [2:0]        new_lvl_s;

    logic [1:0] state_q, state_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_q, spur_d;
    logic       int_q, int_d;
    logic [2:0] cas_out_q, cas_out_d;
    logic       cas_oe_q, cas_oe_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic [7:0] isr_set_q, isr_set_d;
    logic       sel_q, sel_d;
`ifdef AUTO_EOI_EN
    logic       issued_q, issued_d;
    logic [7:0] isr_clr_q, isr_clr_d;
`endif

    assign fall_s    = prev_q & ~sync_q[SYNC_N-1];
    assign rise_s    = ~prev_q & sync_q[SYNC_N-1];
    assign new_lvl_s = INT_REQ_VALID ? INT_LEVEL : SPURIOUS_LEVEL;

    // Synchroniser idles high so reset never fabricates an INTA edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= {SYNC_N{1'b1}};
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], INTA_N};
            prev_q <= sync_q[SYNC_N-1];
        end
    end

    // Acknowledge sequencer: one state per qualified edge, all outputs registered.
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        spur_d     = spur_q;
        cas_out_d  = cas_out_q;
        cas_oe_d   = cas_oe_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        isr_set_d  = 8'h00;
        sel_d      = sel_q;
`ifdef AUTO_EOI_EN
        issued_d   = issued_q;
        isr_clr_d  = 8'h00;
`endif
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_ACK1;
                    lvl_d   = new_lvl_s;
                    spur_d  = ~INT_REQ_VALID;
                    sel_d   = 1'b0;
`ifdef AUTO_EOI_EN
                    issued_d = SP_EN & INT_REQ_VALID;
`endif
                    if (SP_EN && INT_REQ_VALID) begin
                        isr_set_d = onehot8(new_lvl_s);
                        cas_out_d = ICW3[new_lvl_s] ? new_lvl_s : 3'd0;
                        cas_oe_d  = ICW3[new_lvl_s];
                    end else begin
                        cas_out_d = 3'd0;
                        cas_oe_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK1: begin
                // Slave decides whether it is addressed from the cascade ID.
                if (rise_s) begin
                    state_d = ST_GAP;
                    if (!SP_EN && (CAS_IN == ICW3[2:0])) begin
                        sel_d     = 1'b1;
                        isr_set_d = spur_q ? 8'h00 : onehot8(lvl_q);
`ifdef AUTO_EOI_EN
                        issued_d  = ~spur_q;
`endif
                    end else begin
                        sel_d = 1'b0;
                    end
                end else begin
                    state_d = ST_ACK1;
                end
            end
            ST_GAP: begin
                if (fall_s) begin
                    state_d    = ST_ACK2;
                    data_out_d = {ICW2_T, lvl_q};
                    data_oe_d  = SP_EN ? ~cas_oe_q : sel_q;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_ACK2: begin
                if (rise_s) begin
                    state_d    = ST_IDLE;
                    cas_out_d  = 3'd0;
                    cas_oe_d   = 1'b0;
                    data_out_d = 8'h00;
                    data_oe_d  = 1'b0;
                    sel_d      = 1'b0;
`ifdef AUTO_EOI_EN
                    isr_clr_d  = issued_q ? onehot8(lvl_q) : 8'h00;
                    issued_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_ACK2;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        int_d = (state_d == ST_IDLE) & INT_REQ_VALID;
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            lvl_q      <= 3'd0;
            spur_q     <= 1'b0;
            int_q      <= 1'b0;
            cas_out_q  <= 3'd0;
            cas_oe_q   <= 1'b0;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            isr_set_q  <= 8'h00;
            sel_q      <= 1'b0;
`ifdef AUTO_EOI_EN
            issued_q   <= 1'b0;
            isr_clr_q  <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            spur_q     <= spur_d;
            int_q      <= int_d;
            cas_out_q  <= cas_out_d;
            cas_oe_q   <= cas_oe_d;
            data_out_q <= data_out_d;
            data_oe_q  <= data_oe_d;
            isr_set_q  <= isr_set_d;
            sel_q      <= sel_d;
`ifdef AUTO_EOI_EN
            issued_q   <= issued_d;
            isr_clr_q  <= isr_clr_d;
`endif
        end
    end

    assign INT      = int_q;
    assign CAS_OUT  = cas_out_q;
    assign CAS_OE   = cas_oe_q;
    assign DATA_OUT = data_out_q;
    assign DATA_OE  = data_oe_q;
    assign ISR_SET  = isr_set_q;
    assign SELECTED = sel_q;
`ifdef AUTO_EOI_EN
    assign ISR_CLR  = isr_clr_q;
`endif

endmodule

// File: tb/tb_inta_ack_responder.sv
// Self-checking bench for inta_ack_responder: expected output snapshots are
// queued when each INTA edge is driven and compared once the response is due.
module tb_inta_ack_responder;

    localparam int SYNC = 2;

    typedef logic [30:0] obs_t;  // {INT,CAS_OE,CAS_OUT,DATA_OE,DATA_OUT,ISR_SET,SELECTED,ISR_CLR}

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       INTA_N = 1'b1;
    logic       SP_EN = 1'b1;
    logic [7:0] ICW3 = 8'h00;
    logic [4:0] ICW2_T = 5'h00;
    logic       INT_REQ_VALID = 1'b0;
    logic [2:0] INT_LEVEL = 3'd0;
    logic [2:0] CAS_IN = 3'd0;
    logic       INT;
    logic [2:0] CAS_OUT;
    logic       CAS_OE;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;
    logic [7:0] ISR_SET;
    logic       SELECTED;
`ifdef AUTO_EOI_EN
    logic [7:0] ISR_CLR;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    obs_t sb[$];
    obs_t got, e;

    inta_ack_responder #(.SYNC_STAGES(SYNC), .SPURIOUS_LEVEL(3'd7)) dut (
        .CLK(CLK), .RST_N(RST_N), .INTA_N(INTA_N), .SP_EN(SP_EN), .ICW3(ICW3),
        .ICW2_T(ICW2_T), .INT_REQ_VALID(INT_REQ_VALID), .INT_LEVEL(INT_LEVEL),
        .CAS_IN(CAS_IN), .INT(INT), .CAS_OUT(CAS_OUT), .CAS_OE(CAS_OE),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .ISR_SET(ISR_SET), .SELECTED(SELECTED)
`ifdef AUTO_EOI_EN
        , .ISR_CLR(ISR_CLR)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic obs_t sample();
        logic [7:0] clr;
`ifdef AUTO_EOI_EN
        clr = ISR_CLR;
`else
        clr = 8'h00;
`endif
        return {INT, CAS_OE, CAS_OUT, DATA_OE, DATA_OUT, ISR_SET, SELECTED, clr};
    endfunction

    // Reference model of the outputs after phase ph (1=ACK1 .. 4=back to IDLE);
    // post selects the cycle after, when the one-cycle pulses must be gone.
    function automatic obs_t exp_phase(int ph, bit post, bit master, logic [7:0] icw3,
                                       logic [4:0] t, bit spur, logic [2:0] lvl,
                                       logic [2:0] cas, bit valid);
        logic [7:0] oh, dout, iset, clr;
        logic [2:0] co;
        logic       i, ce, de, s;
        bit         casc, sel, issued;
        oh     = 8'h01 << lvl;
        casc   = master && !spur && icw3[lvl];
        sel    = !master && (cas == icw3[2:0]);
        issued = !spur && (master || sel);
        i = 1'b0; ce = 1'b0; co = 3'd0; de = 1'b0; dout = 8'h00; iset = 8'h00; s = 1'b0; clr = 8'h00;
        if (ph >= 1 && ph <= 3) begin
            ce = casc;
            co = casc ? lvl : 3'd0;
        end
        if (ph == 1) iset = (master && !spur) ? oh : 8'h00;
        if (ph == 2) iset = (sel && !spur) ? oh : 8'h00;
        if (ph == 2 || ph == 3) s = sel;
        if (ph == 3) begin
            dout = {t, lvl};
            de   = master ? !casc : sel;
        end
        if (ph == 4) begin
            i = valid;
`ifdef AUTO_EOI_EN
            clr = issued ? oh : 8'h00;
`endif
        end
        if (post) begin
            iset = 8'h00;
            clr  = 8'h00;
        end
        return {i, ce, co, de, dout, iset, s, clr};
    endfunction

    task automatic inta_edge(input logic v);
        @(negedge CLK);
        INTA_N = v;
        repeat (SYNC + 1) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        INT_REQ_VALID = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        vectors++;
        if (sample() !== 31'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", sample(), 31'h0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        vectors++;
        if (INT !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_int: got %b expected 1", INT);
        end
    endtask

    task automatic test_master();
        logic [7:0] icw3_tab [3] = '{8'h00, 8'h04, 8'h00};
        logic [4:0] t_tab    [3] = '{5'h08, 5'h08, 5'h0C};
        logic [2:0] lvl_tab  [3] = '{3'd3, 3'd2, 3'd6};
        for (int k = 0; k < 3; k++) begin
            SP_EN = 1'b1; ICW3 = icw3_tab[k]; ICW2_T = t_tab[k];
            INT_LEVEL = lvl_tab[k]; INT_REQ_VALID = 1'b1;
            for (int ph = 1; ph <= 4; ph++) begin
                sb.push_back(exp_phase(ph, 1'b0, 1'b1, icw3_tab[k], t_tab[k], 1'b0, lvl_tab[k], 3'd0, 1'b1));
                sb.push_back(exp_phase(ph, 1'b1, 1'b1, icw3_tab[k], t_tab[k], 1'b0, lvl_tab[k], 3'd0, 1'b1));
                inta_edge((ph % 2 == 1) ? 1'b0 : 1'b1);
                for (int p = 0; p < 2; p++) begin
                    if (p == 1) begin
                        @(posedge CLK);
                        #1;
                    end
                    e = sb.pop_front();
                    got = sample();
                    vectors++;
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL master%0d_ph%0d_%0d: got %h expected %h", k, ph, p, got, e);
                    end
                end
            end
            repeat (2) @(posedge CLK);
        end
    endtask

    task automatic test_slave();
        logic [2:0] cas_tab [2] = '{3'd2, 3'd3};
        for (int k = 0; k < 2; k++) begin
            SP_EN = 1'b0; ICW3 = 8'h02; ICW2_T = 5'h10; CAS_IN = cas_tab[k];
            INT_LEVEL = 3'd5; INT_REQ_VALID = 1'b1;
            for (int ph = 1; ph <= 4; ph++) begin
                sb.push_back(exp_phase(ph, 1'b0, 1'b0, 8'h02, 5'h10, 1'b0, 3'd5, cas_tab[k], 1'b1));
                sb.push_back(exp_phase(ph, 1'b1, 1'b0, 8'h02, 5'h10, 1'b0, 3'd5, cas_tab[k], 1'b1));
                inta_edge((ph % 2 == 1) ? 1'b0 : 1'b1);
                for (int p = 0; p < 2; p++) begin
                    if (p == 1) begin
                        @(posedge CLK);
                        #1;
                    end
                    e = sb.pop_front();
                    got = sample();
                    vectors++;
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL slave_cas%0d_ph%0d_%0d: got %h expected %h", cas_tab[k], ph, p, got, e);
                    end
                end
                if (ph == 1) INT_LEVEL = 3'd1;  // latched level must stay frozen
            end
            repeat (2) @(posedge CLK);
        end
    endtask

    task automatic test_spurious();
        SP_EN = 1'b1; ICW3 = 8'h80; ICW2_T = 5'h15; INT_LEVEL = 3'd4; INT_REQ_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        for (int ph = 1; ph <= 4; ph++) begin
            sb.push_back(exp_phase(ph, 1'b0, 1'b1, 8'h80, 5'h15, 1'b1, 3'd7, 3'd0, 1'b0));
            sb.push_back(exp_phase(ph, 1'b1, 1'b1, 8'h80, 5'h15, 1'b1, 3'd7, 3'd0, 1'b0));
            if (ph == 1) begin
                @(negedge CLK);
                INTA_N = 1'b0;
                repeat (SYNC) @(posedge CLK);
                #1;
                INT_REQ_VALID = 1'b0;
                @(posedge CLK);
                #1;
            end else begin
                inta_edge((ph % 2 == 1) ? 1'b0 : 1'b1);
            end
            for (int p = 0; p < 2; p++) begin
                if (p == 1) begin
                    @(posedge CLK);
                    #1;
                end
                e = sb.pop_front();
                got = sample();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL spurious_ph%0d_%0d: got %h expected %h", ph, p, got, e);
                end
            end
        end
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_reset_mid();
        SP_EN = 1'b1; ICW3 = 8'h04; ICW2_T = 5'h08; INT_LEVEL = 3'd2; INT_REQ_VALID = 1'b1;
        repeat (2) @(posedge CLK);
        for (int ph = 1; ph <= 2; ph++) begin
            sb.push_back(exp_phase(ph, 1'b0, 1'b1, 8'h04, 5'h08, 1'b0, 3'd2, 3'd0, 1'b1));
            inta_edge((ph == 1) ? 1'b0 : 1'b1);
            e = sb.pop_front();
            got = sample();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL resetmid_pre_ph%0d: got %h expected %h", ph, got, e);
            end
        end
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        vectors++;
        if (sample() !== 31'h0) begin
            miscompares++;
            $display("FAIL resetmid_async: got %h expected %h", sample(), 31'h0);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
        for (int ph = 1; ph <= 4; ph++) begin
            sb.push_back(exp_phase(ph, 1'b0, 1'b1, 8'h04, 5'h08, 1'b0, 3'd2, 3'd0, 1'b1));
            sb.push_back(exp_phase(ph, 1'b1, 1'b1, 8'h04, 5'h08, 1'b0, 3'd2, 3'd0, 1'b1));
            inta_edge((ph % 2 == 1) ? 1'b0 : 1'b1);
            for (int p = 0; p < 2; p++) begin
                if (p == 1) begin
                    @(posedge CLK);
                    #1;
                end
                e = sb.pop_front();
                got = sample();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL resetmid_post_ph%0d_%0d: got %h expected %h", ph, p, got, e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_master();
        test_slave();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
